// File: rtl/tetris_pkg.sv
// Shared encodings for the piece RAM writer: operation modes, FSM states,
// offset packing and cell count.
package tetris_pkg;

  localparam int OFF_W     = 2;
  localparam int NUM_CELLS = 4;
  localparam int OFFS_W    = OFF_W * NUM_CELLS;
  localparam int CELL_IW   = $clog2(NUM_CELLS);

  typedef enum logic [1:0] {
    MODE_WRITE = 2'b00,
    MODE_ERASE = 2'b01,
    MODE_CHECK = 2'b10
  } piece_mode_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_ACT,
    S_NEXT,
    S_DONE
  } piece_state_e;

  // Encoding 2'b11 is treated as CHECK.
  function automatic logic mode_is_check(input logic [1:0] m);
    return (m != MODE_WRITE) && (m != MODE_ERASE);
  endfunction

  function automatic logic [OFF_W-1:0] cell_off(input logic [OFFS_W-1:0] offs,
                                                input logic [CELL_IW-1:0] idx);
    return offs[{idx, 1'b0} +: OFF_W];
  endfunction

endpackage

// File: rtl/piece_cell_addr.sv
// Combinational anchor+offset to linear board address. Range flag is only
// computed when PIECE_RAM_BOUNDS_CHECK_EN is defined, otherwise tied low.
module piece_cell_addr
  import tetris_pkg::*;
#(
  parameter int BOARD_W = 10,
  parameter int BOARD_H = 24,
  parameter int XW      = 4,
  parameter int YW      = 5,
  parameter int ADDR_W  = 8
) (
  input  logic [XW-1:0]     x_anc,
  input  logic [YW-1:0]     y_anc,
  input  logic [OFF_W-1:0]  x_off,
  input  logic [OFF_W-1:0]  y_off,
  output logic [ADDR_W-1:0] addr,
  output logic              oob
);

  logic [XW:0] x;
  logic [YW:0] y;

  // One extra bit so anchor+offset never wraps before the range check.
  always_comb begin
    x    = {1'b0, x_anc} + (XW+1)'(x_off);
    y    = {1'b0, y_anc} + (YW+1)'(y_off);
    addr = ADDR_W'(int'(y) * BOARD_W + int'(x));
`ifdef PIECE_RAM_BOUNDS_CHECK_EN
    oob  = (int'(x) >= BOARD_W) || (int'(y) >= BOARD_H);
`else
    oob  = 1'b0;
`endif
  end

endmodule

// File: rtl/piece_ram_writer.sv
// Writes, erases or collision-checks a 4-cell piece against a board RAM.
// Optional range check on cell coordinates: PIECE_RAM_BOUNDS_CHECK_EN.
module piece_ram_writer
  import tetris_pkg::*;
#(
  parameter  int BOARD_W = 10,
  parameter  int BOARD_H = 24,
  parameter  int DATA_W  = 6,
  localparam int XW      = $clog2(BOARD_W),
  localparam int YW      = $clog2(BOARD_H),
  localparam int ADDR_W  = $clog2(BOARD_W * BOARD_H)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [XW-1:0]     x_anc,
  input  logic [YW-1:0]     y_anc,
  input  logic [OFFS_W-1:0] x_offsets,
  input  logic [OFFS_W-1:0] y_offsets,
  input  logic [DATA_W-1:0] cell_data,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy,
  output logic              done,
  output logic              collision,
  output logic              oob
);

  piece_state_e        state_q;
  logic [1:0]          mode_q;
  logic [XW-1:0]       xa_q;
  logic [YW-1:0]       ya_q;
  logic [OFFS_W-1:0]   xo_q, yo_q;
  logic [CELL_IW-1:0]  cell_q;
  logic                cell_oob_q;
  logic [ADDR_W-1:0]   ram_addr_q;
  logic [DATA_W-1:0]   ram_wdata_q;
  logic                ram_wren_q, busy_q, done_q, collision_q, oob_q;

  logic [XW-1:0]       sel_xa;
  logic [YW-1:0]       sel_ya;
  logic [OFFS_W-1:0]   sel_xo, sel_yo;
  logic [CELL_IW-1:0]  sel_idx;
  logic [ADDR_W-1:0]   cell_addr;
  logic                cell_oob;

  // Address is registered on entry to ADDR, so cell 0 comes straight from
  // the ports while later cells come from the latched request.
  always_comb begin
    sel_xa  = xa_q;
    sel_ya  = ya_q;
    sel_xo  = xo_q;
    sel_yo  = yo_q;
    sel_idx = cell_q + CELL_IW'(1);
    if (state_q == S_IDLE) begin
      sel_xa  = x_anc;
      sel_ya  = y_anc;
      sel_xo  = x_offsets;
      sel_yo  = y_offsets;
      sel_idx = '0;
    end
  end

  piece_cell_addr #(
    .BOARD_W (BOARD_W),
    .BOARD_H (BOARD_H),
    .XW      (XW),
    .YW      (YW),
    .ADDR_W  (ADDR_W)
  ) u_addr (
    .x_anc (sel_xa),
    .y_anc (sel_ya),
    .x_off (cell_off(sel_xo, sel_idx)),
    .y_off (cell_off(sel_yo, sel_idx)),
    .addr  (cell_addr),
    .oob   (cell_oob)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      mode_q      <= '0;
      xa_q        <= '0;
      ya_q        <= '0;
      xo_q        <= '0;
      yo_q        <= '0;
      cell_q      <= '0;
      cell_oob_q  <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      ram_wren_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      collision_q <= 1'b0;
      oob_q       <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            mode_q      <= mode;
            xa_q        <= x_anc;
            ya_q        <= y_anc;
            xo_q        <= x_offsets;
            yo_q        <= y_offsets;
            cell_q      <= '0;
            cell_oob_q  <= cell_oob;
            ram_addr_q  <= cell_addr;
            ram_wdata_q <= (mode == MODE_WRITE) ? cell_data : '0;
            collision_q <= 1'b0;
            oob_q       <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= S_ADDR;
          end
        end
        S_ADDR: begin
          ram_wren_q <= !mode_is_check(mode_q) && !cell_oob_q;
          state_q    <= S_ACT;
        end
        S_ACT: begin
          ram_wren_q <= 1'b0;
          state_q    <= S_NEXT;
        end
        S_NEXT: begin
          // Read data for this cell has been valid since the ACT cycle.
          if (mode_is_check(mode_q))
            collision_q <= collision_q | (ram_rdata != '0) | cell_oob_q;
          oob_q <= oob_q | cell_oob_q;
          if (cell_q == CELL_IW'(NUM_CELLS - 1)) begin
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            cell_q     <= cell_q + CELL_IW'(1);
            cell_oob_q <= cell_oob;
            ram_addr_q <= cell_addr;
            state_q    <= S_ADDR;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign ram_wren  = ram_wren_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign collision = collision_q;
  assign oob       = oob_q;

endmodule

// File: tb/tb_piece_ram_writer.sv
// Directed bench for piece_ram_writer with a 1-cycle registered-read RAM model.
module tb_piece_ram_writer;
  import tetris_pkg::*;

  localparam int BW = 10, BH = 24, DW = 6;
  localparam int XW = 4, YW = 5, AW = 8;

  logic          clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [1:0]    mode = '0;
  logic [XW-1:0] x_anc = '0;
  logic [YW-1:0] y_anc = '0;
  logic [7:0]    x_offsets = '0, y_offsets = '0;
  logic [DW-1:0] cell_data = '0;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata, ram_rdata;
  logic          ram_wren, busy, done, collision, oob;

  always #5 clk = ~clk;

  piece_ram_writer #(.BOARD_W(BW), .BOARD_H(BH), .DATA_W(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .mode      (mode),
    .x_anc     (x_anc),
    .y_anc     (y_anc),
    .x_offsets (x_offsets),
    .y_offsets (y_offsets),
    .cell_data (cell_data),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_wren  (ram_wren),
    .ram_rdata (ram_rdata),
    .busy      (busy),
    .done      (done),
    .collision (collision),
    .oob       (oob)
  );

  logic [DW-1:0] mem [0:BW*BH-1];
  logic          tb_we = 1'b0, tb_clr = 1'b0;
  logic [AW-1:0] tb_addr = '0;
  logic [DW-1:0] tb_data = '0;
  int            done_cnt = 0, wren_cnt = 0;

  always @(posedge clk) begin
    if (tb_clr) begin
      for (int i = 0; i < BW*BH; i++) mem[i] <= '0;
    end else if (tb_we) mem[tb_addr] <= tb_data;
    else if (ram_wren) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
    if (done) done_cnt <= done_cnt + 1;
    if (ram_wren) wren_cnt <= wren_cnt + 1;
  end

  int            n_tests = 0, n_fail = 0;
  int            nw, prof_err;
  logic [AW-1:0] w_addr [8];
  logic [DW-1:0] w_data [8];
  int            w_cyc  [8];
  logic          coll13, oob13;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_w(input string tag, input int i, input int a, input int c, input int d);
    chk({tag, " addr"}, 32'(w_addr[i]), a);
    chk({tag, " cycle"}, w_cyc[i], c);
    chk({tag, " data"}, 32'(w_data[i]), d);
  endtask

  task automatic poke(input int a, input int d);
    @(negedge clk);
    tb_we = 1'b1; tb_addr = AW'(a); tb_data = DW'(d);
    @(negedge clk);
    tb_we = 1'b0;
  endtask

  // One full operation; checks busy/done profile, address stability,
  // clearing of flags on accept, and that inputs are latched.
  task automatic run_op(input logic [1:0] m, input int xa, input int ya,
                        input logic [7:0] xo, input logic [7:0] yo, input int d);
    logic [AW-1:0] a_ref;
    nw = 0; prof_err = 0; a_ref = '0;
    @(negedge clk);
    start = 1'b1; mode = m; x_anc = XW'(xa); y_anc = YW'(ya);
    x_offsets = xo; y_offsets = yo; cell_data = DW'(d);
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      if (c == 1) begin
        start = 1'b0; mode = 2'($urandom); x_anc = XW'($urandom);
        y_anc = YW'($urandom); x_offsets = 8'($urandom);
        y_offsets = 8'($urandom); cell_data = DW'($urandom);
        if (collision !== 1'b0 || oob !== 1'b0) prof_err++;
      end
      if (busy !== (c <= 13)) prof_err++;
      if (done !== (c == 13)) prof_err++;
      if (c <= 12) begin
        if (c % 3 == 1) a_ref = ram_addr;
        else if (ram_addr !== a_ref) prof_err++;
      end
      if (ram_wren === 1'b1) begin
        if (nw < 8) begin
          w_addr[nw] = ram_addr; w_data[nw] = ram_wdata; w_cyc[nw] = c;
        end
        nw++;
      end
      if (c == 13) begin coll13 = collision; oob13 = oob; end
      if (c == 14 && (collision !== coll13 || oob !== oob13)) prof_err++;
    end
  endtask

  initial begin
    int d0, w0, got;
    tb_clr = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset ctrl", {ram_wren, busy, done, collision, oob}, 0);
    chk("reset addr/wdata", {ram_addr, ram_wdata}, 0);
    reset = 1'b0; tb_clr = 1'b0;

    // CHECK against a board with only addr 54 occupied
    poke(54, 1);
    run_op(2'b10, 3, 5, 8'b00_01_10_11, 8'h00, 6'h3F);
    chk("chk1 profile", prof_err, 0);
    chk("chk1 wren count", nw, 0);
    chk("chk1 collision", coll13, 1);
    chk("chk1 oob", oob13, 0);

    run_op(2'b11, 3, 5, 8'b00_01_10_11, 8'h00, 6'h3F);
    chk("mode11 profile", prof_err, 0);
    chk("mode11 wren count", nw, 0);
    chk("mode11 collision", coll13, 1);

    poke(54, 0);
    run_op(2'b10, 3, 5, 8'b00_01_10_11, 8'h00, 6'h3F);
    chk("chk empty collision", coll13, 0);
    chk("chk empty profile", prof_err, 0);

    // WRITE anchor (3,5): cells x=6,5,4,3 on row 5
    run_op(2'b00, 3, 5, 8'b00_01_10_11, 8'h00, 6'h2A);
    chk("wr profile", prof_err, 0);
    chk("wr count", nw, 4);
    chk_w("wr c0", 0, 56, 2, 6'h2A);
    chk_w("wr c1", 1, 55, 5, 6'h2A);
    chk_w("wr c2", 2, 54, 8, 6'h2A);
    chk_w("wr c3", 3, 53, 11, 6'h2A);
    chk("wr collision", coll13, 0);
    for (int a = 53; a <= 56; a++) chk("wr mem", 32'(mem[a]), 6'h2A);

    run_op(2'b10, 3, 5, 8'b00_01_10_11, 8'h00, 6'h00);
    chk("chk after wr collision", coll13, 1);

    run_op(2'b01, 3, 5, 8'b00_01_10_11, 8'h00, 6'h2A);
    chk("er profile", prof_err, 0);
    chk("er count", nw, 4);
    chk_w("er c0", 0, 56, 2, 0);
    chk_w("er c3", 3, 53, 11, 0);
    chk("er collision", coll13, 0);
    for (int a = 53; a <= 56; a++) chk("er mem", 32'(mem[a]), 0);

    run_op(2'b10, 3, 5, 8'b00_01_10_11, 8'h00, 6'h00);
    chk("chk after er collision", coll13, 0);

    // Anchor (9,0), cell1 one column right of the board edge
    run_op(2'b00, 9, 0, 8'b00_00_01_00, 8'b11_10_01_00, 6'h15);
    chk("edge profile", prof_err, 0);
`ifdef PIECE_RAM_BOUNDS_CHECK_EN
    chk("edge count", nw, 3);
    chk_w("edge c0", 0, 9, 2, 6'h15);
    chk_w("edge c2", 1, 29, 8, 6'h15);
    chk_w("edge c3", 2, 39, 11, 6'h15);
    chk("edge oob", oob13, 1);
    chk("edge mem20", 32'(mem[20]), 0);
`else
    chk("edge count", nw, 4);
    chk_w("edge c0", 0, 9, 2, 6'h15);
    chk_w("edge c1", 1, 20, 5, 6'h15);
    chk_w("edge c2", 2, 29, 8, 6'h15);
    chk_w("edge c3", 3, 39, 11, 6'h15);
    chk("edge oob", oob13, 0);
`endif

    // CHECK where only the out-of-range cell could collide (addr 60 empty)
    run_op(2'b10, 9, 5, 8'b00_00_01_00, 8'h00, 6'h00);
`ifdef PIECE_RAM_BOUNDS_CHECK_EN
    chk("edge chk collision", coll13, 1);
    chk("edge chk oob", oob13, 1);
`else
    chk("edge chk collision", coll13, 0);
    chk("edge chk oob", oob13, 0);
`endif
    chk("edge chk wren count", nw, 0);

    // start pulsed while busy must be ignored
    d0 = done_cnt; w0 = wren_cnt;
    @(negedge clk);
    start = 1'b1; mode = 2'b00; x_anc = '0; y_anc = '0;
    x_offsets = 8'h00; y_offsets = 8'b11_10_01_00; cell_data = 6'h07;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      if (c == 4) begin start = 1'b1; mode = 2'b01; end
      if (c == 5) start = 1'b0;
    end
    chk("busy start done count", done_cnt - d0, 1);
    chk("busy start wren count", wren_cnt - w0, 4);
    chk("busy start mem0", 32'(mem[0]), 6'h07);
    chk("busy start mem30", 32'(mem[30]), 6'h07);

    // start held high restarts the cycle after returning to IDLE
    @(negedge clk);
    start = 1'b1; mode = 2'b10; x_anc = '0; y_anc = '0;
    x_offsets = '0; y_offsets = '0;
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      if (c == 13) chk("held done", done, 1);
      if (c == 14) chk("held idle gap", {busy, done}, 0);
      if (c == 15) chk("held restart busy", busy, 1);
    end
    start = 1'b0;
    got = 0;
    for (int k = 0; k < 20 && got == 0; k++) begin
      @(negedge clk);
      if (done === 1'b1) got = 1;
    end
    chk("held second done", got, 1);
    @(negedge clk);
    @(negedge clk);
    chk("held final idle", busy, 0);

    // reset mid-operation, with start also high: reset wins
    d0 = done_cnt;
    @(negedge clk);
    start = 1'b1; mode = 2'b00; x_anc = XW'(3); y_anc = YW'(5);
    x_offsets = 8'b00_01_10_11; y_offsets = '0; cell_data = 6'h2A;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst pre wren", ram_wren, 1);
    reset = 1'b1; start = 1'b1;
    @(negedge clk);
    chk("rst ctrl", {ram_wren, busy, done, collision, oob}, 0);
    chk("rst addr/wdata", {ram_addr, ram_wdata}, 0);
    reset = 1'b0; start = 1'b0;
    repeat (16) @(negedge clk);
    chk("rst no done", done_cnt - d0, 0);
    chk("rst stays idle", busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/piece_ram_writer.md
PIECE_RAM_WRITER -- requirements
Module: piece_ram_writer

Interface
REQ-001 SHALL have parameter BOARD_W, default 10, board columns.
REQ-002 SHALL have parameter BOARD_H, default 24, board rows.
REQ-003 SHALL have parameter DATA_W, default 6, cell data width.
REQ-004 SHALL derive localparams XW=clog2(BOARD_W), YW=clog2(BOARD_H), ADDR_W=clog2(BOARD_W*BOARD_H).
REQ-005 SHALL have port clk  in  1  single clock; all logic on posedge.
REQ-006 SHALL have port reset  in  1  synchronous active-high reset.
REQ-007 SHALL have port start  in  1  request; sampled only in IDLE.
REQ-008 SHALL have port mode  in  2  00 WRITE, 01 ERASE, 10 CHECK, 11 decoded as CHECK.
REQ-009 SHALL have ports x_anc  in  XW and y_anc  in  YW  piece anchor.
REQ-010 SHALL have ports x_offsets  in  8 and y_offsets  in  8  four packed 2-bit offsets, cell i at bits [2i+1:2i].
REQ-011 SHALL have port cell_data  in  DATA_W  value stored by WRITE.
REQ-012 SHALL have ports ram_addr  out  ADDR_W, ram_wdata  out  DATA_W, ram_wren  out  1, ram_rdata  in  DATA_W  single-port RAM, 1-cycle registered read.
REQ-013 SHALL have ports busy, done, collision, oob  out  1 each.

Function
REQ-014 SHALL latch mode, anchors, offsets and cell_data on the cycle start is accepted; later input changes have no effect until the next request.
REQ-015 SHALL implement FSM IDLE -> ADDR -> ACT -> NEXT -> (ADDR for next cell | DONE) -> IDLE; cells processed 0..3.
REQ-016 ADDR: SHALL register x=x_anc+xoff_i and y=y_anc+yoff_i computed one bit wider than XW/YW, ram_addr=y*BOARD_W+x truncated to ADDR_W, ram_wdata=cell_data (WRITE) or 0 (ERASE/CHECK).
REQ-017 ACT: SHALL drive ram_wren=1 for exactly one cycle in WRITE/ERASE for an in-bounds cell; ram_wren=0 always in CHECK.
REQ-018 NEXT: SHALL drive ram_wren=0; in CHECK SHALL sample ram_rdata and set sticky collision if nonzero.
REQ-019 ram_addr and ram_wdata SHALL be stable from ADDR through NEXT of each cell.
REQ-020 Latency: start accepted at edge 0 -> busy=1 cycles 1..13, cells occupy cycles 1..12, done=1 for exactly cycle 13, IDLE at cycle 14.
REQ-021 start while busy SHALL be ignored; start held high SHALL begin a new operation in the cycle after DONE returns to IDLE.
REQ-022 collision and oob SHALL clear on acceptance of a new start and hold their final value from DONE until the next start.
REQ-023 collision SHALL remain 0 in WRITE/ERASE.

Reset
REQ-024 reset SHALL force IDLE, ram_wren=0, busy=0, done=0, collision=0, oob=0, ram_addr=0, ram_wdata=0 on the next edge, including mid-operation; reset has priority over start.

Configuration
REQ-025 With PIECE_RAM_BOUNDS_CHECK_EN defined: a cell with x>=BOARD_W or y>=BOARD_H SHALL set sticky oob, SHALL suppress ram_wren for that cell, and in CHECK SHALL also set collision; timing unchanged.
REQ-026 Without PIECE_RAM_BOUNDS_CHECK_EN: no range check, oob tied 0, address used as truncated per REQ-016.

Structure
REQ-027 Mode encodings, offset packing width (2) and cell count (4) SHALL live in shared package tetris_pkg.
REQ-028 Coordinate-to-address arithmetic SHALL be one sub-module piece_cell_addr (parametrised BOARD_W, XW, YW, ADDR_W; combinational, registered by caller).

Verification
REQ-029 WRITE, anchor (3,5), x_off=8'b00_01_10_11, y_off=0, cell_data=6'h2A -> wren pulses at addr 56,55,54,53 (cycles 2,5,8,11), done at cycle 13.
REQ-030 CHECK on board with addr 54 = 6'h01, same piece -> no wren, collision=1 at done; repeat on empty board -> collision=0.
REQ-031 ERASE after REQ-029 -> four wren pulses with ram_wdata=0; subsequent CHECK -> collision=0.
REQ-032 Macro on, WRITE anchor (9,0), x_off cell1=1 -> cell1 wren suppressed, oob=1, other cells written; macro off -> oob=0, four writes.
REQ-033 reset asserted at cycle 6 of a WRITE -> ram_wren=0 and busy=0 next cycle, done never pulses; start pulse during busy -> ignored, exactly one done.
